// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control FSM for the MM:SS stopwatch. Turns the divider's level clocks into
//   single-cycle ticks, debounces the user buttons/switches, sequences the
//   RUN / PAUSED / ADJUST modes, keeps the time count and drives per-field
//   display blanking. Pulses DIV_RES whenever the time is cleared so the
//   divider restarts its phase together with the count.
//
// Ports
//   CLK_REF    in   system clock, all state on rising edge
//   CLK_RES    in   asynchronous active-high reset
//   BTN_PAUSE  in   raw pause/resume button
//   BTN_RESET  in   raw clear-time button
//   SW_ADJ     in   raw adjust-mode switch (1 = adjust)
//   SW_SEL     in   raw adjust field select (0 = minutes, 1 = seconds)
//   CLK_1HZ    in   1 Hz level clock from the divider
//   CLK_2HZ    in   2 Hz level clock from the divider
//   CLK_BLINK  in   blink level clock from the divider
//   DIV_RES    out  one-cycle divider reset, coincident with the time clear
//   MIN, SEC   out  time fields, binary 0..59
//   BLANK_MIN  out  blank the minutes digits
//   BLANK_SEC  out  blank the seconds digits
//   STATE      out  00 RUN, 01 PAUSED, 10 ADJUST
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLK_REF,
  input  logic       CLK_RES,
  input  logic       BTN_PAUSE,
  input  logic       BTN_RESET,
  input  logic       SW_ADJ,
  input  logic       SW_SEL,
  input  logic       CLK_1HZ,
  input  logic       CLK_2HZ,
  input  logic       CLK_BLINK,
  output logic       DIV_RES,
  output logic [5:0] MIN,
  output logic [5:0] SEC,
  output logic       BLANK_MIN,
  output logic       BLANK_SEC,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_PAUSED = 2'b01,
    ST_ADJUST = 2'b10
  } state_t;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Divider clocks: 2-flop synchronizer, rising-edge detect on 1 Hz and 2 Hz.
  // Bit order: [0] 1 Hz, [1] 2 Hz, [2] blink.
  // ---------------------------------------------------------------------------
  logic [2:0] div_s1, div_s2;
  logic [1:0] div_prev;
  logic       tick_1hz, tick_2hz, blink;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the 2-flop
  // synchronizer chain actually two stages deep.
  always_ff @(posedge CLK_REF or posedge CLK_RES) begin
    if (CLK_RES) begin
      div_s1   <= '0;
      div_s2   <= '0;
      div_prev <= '0;
    end else begin
      div_s1   <= {CLK_BLINK, CLK_2HZ, CLK_1HZ};
      div_s2   <= div_s1;
      div_prev <= div_s2[1:0];
    end
  end

  assign tick_1hz = div_s2[0] & ~div_prev[0];
  assign tick_2hz = div_s2[1] & ~div_prev[1];
  assign blink    = div_s2[2];

  // ---------------------------------------------------------------------------
  // User inputs: synchronize, then debounce. The debounced level only follows
  // the synchronized level after DEBOUNCE_CYCLES consecutive differing cycles;
  // any cycle that agrees restarts the count.
  // Bit order: [0] pause, [1] reset, [2] adj, [3] sel.
  // ---------------------------------------------------------------------------
  logic [3:0]       btn_s1, btn_s2, db, db_prev;
  logic [CNT_W-1:0] db_cnt [4];
  logic             press_pause, press_reset, adj, sel;

  // NOTE: the debounce counters are four ordinary registers, not a RAM, so they
  // take the asynchronous reset like everything else; a reset mid-debounce
  // therefore aborts the count.
  always_ff @(posedge CLK_REF or posedge CLK_RES) begin
    if (CLK_RES) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      btn_s1  <= {SW_SEL, SW_ADJ, BTN_RESET, BTN_PAUSE};
      btn_s2  <= btn_s1;
      db_prev <= db;
      for (int i = 0; i < 4; i++) begin
        if (btn_s2[i] != db[i]) begin
          if (db_cnt[i] == CNT_LAST) begin
            db[i]     <= btn_s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CNT_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press_pause = db[0] & ~db_prev[0];
  assign press_reset = db[1] & ~db_prev[1];
  assign adj         = db[2];
  assign sel         = db[3];

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  state_t state_q, state_nxt;

  // NOTE: the default assignment first guarantees every path drives state_nxt,
  // so no latch is inferred.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_PAUSED: if (adj) state_nxt = ST_ADJUST;
                 else if (press_pause) state_nxt = ST_RUN;
      ST_RUN:    if (adj) state_nxt = ST_ADJUST;
                 else if (press_pause) state_nxt = ST_PAUSED;
      ST_ADJUST: if (!adj) state_nxt = ST_PAUSED;
      default:   state_nxt = ST_PAUSED;
    endcase
  end

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // Time count, divider reset and blanking. A clear has priority over any
  // tick landing in the same cycle. Blanking is derived from the next state
  // so it switches on the same edge as STATE.
  always_ff @(posedge CLK_REF or posedge CLK_RES) begin
    if (CLK_RES) begin
      state_q   <= ST_PAUSED;
      MIN       <= '0;
      SEC       <= '0;
      DIV_RES   <= 1'b0;
      BLANK_MIN <= 1'b0;
      BLANK_SEC <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      DIV_RES   <= press_reset;
      BLANK_MIN <= (state_nxt == ST_ADJUST) && !sel && blink;
      BLANK_SEC <= (state_nxt == ST_ADJUST) &&  sel && blink;
      if (press_reset) begin
        MIN <= '0;
        SEC <= '0;
      end else if (state_q == ST_RUN && tick_1hz) begin
        SEC <= inc60(SEC);
        if (SEC == 6'd59) MIN <= inc60(MIN);
      end else if (state_q == ST_ADJUST && tick_2hz) begin
        // Adjust wraps the selected field alone; no carry between fields.
        if (sel) SEC <= inc60(SEC);
        else     MIN <= inc60(MIN);
      end
    end
  end

  assign STATE = state_q;

endmodule
